// File: rtl/adam_pkg.sv
// adam_pkg: constants shared by the Adam weight-update sequencer and its
// gradient clamp.
//   - W / tag constants: every value carries a 2-bit exception tag above an
//     IEEE-754 single (00 zero, 01 normal, 10 inf, 11 NaN).
//   - state_t: sequencer FSM states.
//   - CLIP_MAG: tagged +1.0, the clamp magnitude.
//   - Adam coefficients (tagged single precision), kept here so the update
//     block and the sequencer agree on one source.
package adam_pkg;

    localparam int BIT_WIDTH = 32;
    localparam int EXTRA_BIT = 2;
    localparam int W         = BIT_WIDTH + EXTRA_BIT;

    localparam logic [1:0] TAG_ZERO   = 2'b00;
    localparam logic [1:0] TAG_NORMAL = 2'b01;
    localparam logic [1:0] TAG_INF    = 2'b10;
    localparam logic [1:0] TAG_NAN    = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_GRAD,
        ISSUE,
        WAIT_RES,
        WRITE,
        DONE
    } state_t;

    localparam logic [W-1:0] CLIP_MAG      = {TAG_NORMAL, 32'h3F80_0000};

    localparam logic [W-1:0] BETA_1        = {TAG_NORMAL, 32'h3F66_6666}; // 0.9
    localparam logic [W-1:0] BETA_2        = {TAG_NORMAL, 32'h3F7F_BE77}; // 0.999
    localparam logic [W-1:0] ONE_M_BETA_1  = {TAG_NORMAL, 32'h3DCC_CCCD}; // 0.1
    localparam logic [W-1:0] ONE_M_BETA_2  = {TAG_NORMAL, 32'h3A83_126F}; // 0.001
    localparam logic [W-1:0] EPSILON       = {TAG_NORMAL, 32'h322B_CC77}; // 1e-8

endpackage

// File: rtl/grad_clip.sv
// grad_clip: combinational clamp applied to captured gradients when the
// sequencer is built with GRAD_CLIP_EN.
//   grad_in  [W-1:0] : tagged gradient
//   grad_out [W-1:0] : clamped gradient
// Normals with |g| > 1.0 and infinities become +/-1.0 keeping the sign;
// NaN becomes tagged zero; everything else passes through.
module grad_clip
    import adam_pkg::*;
(
    input  logic [W-1:0] grad_in,
    output logic [W-1:0] grad_out
);

    logic [1:0]  tag;
    logic        sgn;
    logic [30:0] mag;

    assign tag = grad_in[W-1 -: 2];
    assign sgn = grad_in[31];
    assign mag = grad_in[30:0];

    always_comb begin
        grad_out = grad_in;
        if (tag == TAG_NAN) begin
            grad_out = '0;
        end else if ((tag == TAG_INF) ||
                     ((tag == TAG_NORMAL) && (mag > CLIP_MAG[30:0]))) begin
            grad_out = {TAG_NORMAL, sgn, CLIP_MAG[30:0]};
        end
    end

endmodule

// File: rtl/adam_update_sequencer.sv
// adam_update_sequencer: walks a layer's weights in index order and, for each
// weight, reads it, accepts one gradient, fires one single-cycle enable to the
// Adam update block and writes the result back. Exactly NUMBER_WEIGHTS enables
// per pass keep the Adam moment index aligned with the weight index.
//
// Build option: GRAD_CLIP_EN -- route captured gradients through grad_clip.
//
// Ports:
//   clk, rst            clock (rising), asynchronous active-high reset
//   start/busy/done     pass control; done pulses one cycle at pass end
//   pass_count [15:0]   completed passes, wraps
//   grad_valid/ready    gradient stream handshake, grad_data [W-1:0]
//   rd_addr/rd_data     weight memory read (data one cycle after address)
//   old_weight, delta_weight, adam_enable, updated_weight   Adam block link
//   wr_en/wr_addr/wr_data  weight memory write
module adam_update_sequencer
    import adam_pkg::*;
#(
    parameter int BIT_WIDTH      = 32,
    parameter int EXTRA_BIT      = 2,
    parameter int NUMBER_WEIGHTS = 4,
    parameter int UPDATE_LATENCY = 1,
    localparam int DW = BIT_WIDTH + EXTRA_BIT,
    localparam int AW = (NUMBER_WEIGHTS > 1) ? $clog2(NUMBER_WEIGHTS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [15:0]   pass_count,
    input  logic          grad_valid,
    input  logic [DW-1:0] grad_data,
    output logic          grad_ready,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] old_weight,
    output logic [DW-1:0] delta_weight,
    output logic          adam_enable,
    input  logic [DW-1:0] updated_weight,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data
);

    // Latency counter holds UPDATE_LATENCY-1 down to 0.
    localparam int LW = (UPDATE_LATENCY > 1) ? $clog2(UPDATE_LATENCY) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(NUMBER_WEIGHTS - 1);

    state_t          state;
    logic [AW-1:0]   idx;
    logic [LW-1:0]   lat_cnt;
    logic            wg_first;
    logic [DW-1:0]   grad_cap;

`ifdef GRAD_CLIP_EN
    grad_clip u_grad_clip (
        .grad_in  (grad_data),
        .grad_out (grad_cap)
    );
`else
    assign grad_cap = grad_data;
`endif

    // All outputs are registered and set on the transition into the state
    // that owns them, so each is valid for the whole of that state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            lat_cnt      <= '0;
            wg_first     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass_count   <= '0;
            grad_ready   <= 1'b0;
            rd_addr      <= '0;
            old_weight   <= '0;
            delta_weight <= '0;
            adam_enable  <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
        end else begin
            adam_enable <= 1'b0;
            wr_en       <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx     <= '0;
                        rd_addr <= '0;
                        busy    <= 1'b1;
                        state   <= FETCH;
                    end
                end
                FETCH: begin
                    grad_ready <= 1'b1;
                    wg_first   <= 1'b1;
                    state      <= WAIT_GRAD;
                end
                WAIT_GRAD: begin
                    // Read data for rd_addr is valid only in the first cycle
                    // here; later stall cycles must not overwrite it.
                    wg_first <= 1'b0;
                    if (wg_first) begin
                        old_weight <= rd_data;
                    end
                    if (grad_valid && grad_ready) begin
                        grad_ready   <= 1'b0;
                        delta_weight <= grad_cap;
                        adam_enable  <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (UPDATE_LATENCY == 0) begin
                        wr_en   <= 1'b1;
                        wr_addr <= idx;
                        wr_data <= updated_weight;
                        state   <= WRITE;
                    end else begin
                        lat_cnt <= LW'(UPDATE_LATENCY - 1);
                        state   <= WAIT_RES;
                    end
                end
                WAIT_RES: begin
                    if (lat_cnt == '0) begin
                        wr_en   <= 1'b1;
                        wr_addr <= idx;
                        wr_data <= updated_weight;
                        state   <= WRITE;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                WRITE: begin
                    if (idx == LAST_IDX) begin
                        done       <= 1'b1;
                        pass_count <= pass_count + 16'd1;
                        state      <= DONE;
                    end else begin
                        idx     <= idx + 1'b1;
                        rd_addr <= idx + 1'b1;
                        state   <= FETCH;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adam_update_sequencer.sv
// tb_adam_update_sequencer: directed bench for adam_update_sequencer.
// Instance A: N=4, L=1. Instance B: N=1, L=0. The Adam block is modelled as
// old+delta (34-bit wrap), valid only at the prescribed latency.
module tb_adam_update_sequencer;

    localparam int W = 34;
    localparam logic [W-1:0] ONE  = 34'h1_3F80_0000;
    localparam logic [W-1:0] JUNK = 34'h3_DEAD_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // ---------------- instance A ----------------
    logic          start_a = 1'b0, gv_a = 1'b0;
    logic          busy_a, done_a, gr_a, en_a, we_a;
    logic [15:0]   pc_a;
    logic [W-1:0]  gd_a, rdd_a, ow_a, dw_a, uw_a, wd_a;
    logic [1:0]    rda_a, wa_a;

    adam_update_sequencer #(.BIT_WIDTH(32), .EXTRA_BIT(2), .NUMBER_WEIGHTS(4), .UPDATE_LATENCY(1)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .pass_count(pc_a), .grad_valid(gv_a), .grad_data(gd_a), .grad_ready(gr_a),
        .rd_addr(rda_a), .rd_data(rdd_a), .old_weight(ow_a), .delta_weight(dw_a),
        .adam_enable(en_a), .updated_weight(uw_a), .wr_en(we_a), .wr_addr(wa_a),
        .wr_data(wd_a)
    );

    logic          mem_init = 1'b0;
    logic          gptr_clr = 1'b0;
    logic [W-1:0]  mem_a [4];
    logic [W-1:0]  gtab [4];
    logic [1:0]    gptr;

    always @(posedge clk) begin
        rdd_a <= mem_a[rda_a];
        if (mem_init) begin
            for (int i = 0; i < 4; i++) mem_a[i] <= ONE;
        end else if (we_a) begin
            mem_a[wa_a] <= wd_a;
        end
    end

    always @(posedge clk) begin
        if (gptr_clr) gptr <= '0;
        else if (gv_a && gr_a) gptr <= gptr + 1'b1;
    end
    assign gd_a = gtab[gptr];

    always @(posedge clk or posedge rst) begin
        if (rst) uw_a <= '0;
        else     uw_a <= en_a ? (ow_a + dw_a) : JUNK;
    end

    int           s_a = 0, rel_a, done_cyc_a = -1, stall_ready = 0;
    logic [1:0]   fetch_addr;
    int           en_q[$];
    logic [W-1:0] ow_q[$], dw_q[$], wd_q[$];
    logic [1:0]   wa_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            rel_a = cyc - s_a + 1;
            if (en_a) begin
                en_q.push_back(rel_a); ow_q.push_back(ow_a); dw_q.push_back(dw_a);
            end
            if (we_a) begin
                wa_q.push_back(wa_a); wd_q.push_back(wd_a);
            end
            if (done_a && done_cyc_a < 0) done_cyc_a = rel_a;
            if (!gv_a && gr_a) stall_ready++;
            if (rel_a == 1) fetch_addr = rda_a;
        end
    end

    // ---------------- instance B ----------------
    logic          start_b = 1'b0, gv_b = 1'b0;
    logic          busy_b, done_b, gr_b, en_b, we_b;
    logic [15:0]   pc_b;
    logic [W-1:0]  gd_b = 34'h1_3E80_0000;
    logic [W-1:0]  rdd_b, ow_b, dw_b, uw_b, wd_b;
    logic [0:0]    rda_b, wa_b;
    logic [W-1:0]  mem_b;

    adam_update_sequencer #(.BIT_WIDTH(32), .EXTRA_BIT(2), .NUMBER_WEIGHTS(1), .UPDATE_LATENCY(0)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .pass_count(pc_b), .grad_valid(gv_b), .grad_data(gd_b), .grad_ready(gr_b),
        .rd_addr(rda_b), .rd_data(rdd_b), .old_weight(ow_b), .delta_weight(dw_b),
        .adam_enable(en_b), .updated_weight(uw_b), .wr_en(we_b), .wr_addr(wa_b),
        .wr_data(wd_b)
    );

    always @(posedge clk) begin
        rdd_b <= (rda_b == 1'b0) ? mem_b : JUNK;
        if (mem_init) mem_b <= ONE;
        else if (we_b && wa_b == 1'b0) mem_b <= wd_b;
    end
    assign uw_b = en_b ? (ow_b + dw_b) : JUNK;

    int           s_b = 0, rel_b, done_cyc_b = -1;
    int           enb_q[$];
    logic [W-1:0] wdb_q[$];
    logic [0:0]   wab_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            rel_b = cyc - s_b + 1;
            if (en_b) enb_q.push_back(rel_b);
            if (we_b) begin
                wab_q.push_back(wa_b); wdb_q.push_back(wd_b);
            end
            if (done_b && done_cyc_b < 0) done_cyc_b = rel_b;
        end
    end

    // ---------------- helpers ----------------
    logic [W-1:0] exp_mem [4];
    logic [W-1:0] exp_dw [4];

    task automatic clear_a();
        en_q.delete(); ow_q.delete(); dw_q.delete(); wa_q.delete(); wd_q.delete();
        done_cyc_a = -1; stall_ready = 0;
        @(negedge clk) gptr_clr = 1'b1;
        @(negedge clk) gptr_clr = 1'b0;
    endtask

    task automatic start_pass_a();
        @(negedge clk) start_a = 1'b1;
        @(posedge clk);
        #1 s_a = cyc;
        start_a = 1'b0;
    endtask

    task automatic wait_done_a();
        for (int i = 0; i < 100 && done_cyc_a < 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Checks a complete N=4, L=1 pass against exp_mem/exp_dw, then commits.
    task automatic check_pass_a(input string nm, input int en_cyc[4], input int dcyc, input int pc);
        logic [W-1:0] wexp;
        chk({nm, "_en_count"}, en_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            wexp = exp_mem[i] + exp_dw[i];
            chk($sformatf("%s_en_cyc%0d", nm, i), en_q[i], en_cyc[i]);
            chk($sformatf("%s_old%0d", nm, i), ow_q[i], exp_mem[i]);
            chk($sformatf("%s_delta%0d", nm, i), dw_q[i], exp_dw[i]);
            chk($sformatf("%s_wa%0d", nm, i), wa_q[i], i);
            chk($sformatf("%s_wd%0d", nm, i), wd_q[i], wexp);
            exp_mem[i] = wexp;
        end
        chk({nm, "_done_cyc"}, done_cyc_a, dcyc);
        chk({nm, "_pass_count"}, pc_a, pc);
        chk({nm, "_busy_after"}, busy_a, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) gtab[i] = '0;
        // ---------------- reset state ----------------
        #2 rst = 1'b1;
        mem_init = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctl",   {busy_a, done_a, gr_a, en_a, we_a}, 0);
        chk("rst_addr",  {rda_a, wa_a}, 0);
        chk("rst_wdata", wd_a, 0);
        chk("rst_old",   ow_a, 0);
        chk("rst_delta", dw_a, 0);
        chk("rst_pc",    pc_a, 0);
        chk("rst_b_ctl", {busy_b, done_b, gr_b, en_b, we_b, pc_b}, 0);
        @(negedge clk);
        rst = 1'b0;
        mem_init = 1'b0;
        for (int i = 0; i < 4; i++) exp_mem[i] = ONE;

        // ---------------- pass 1: streaming, stray start at cycle 5 ----------------
        gtab = '{34'h1_3E80_0000, 34'h1_BF00_0000, 34'h1_3F00_0000, 34'h0_0000_0000};
        exp_dw = gtab;
        gv_a = 1'b1;
        clear_a();
        start_pass_a();
        repeat (4) @(posedge clk);
        #1 start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        wait_done_a();
        repeat (10) @(posedge clk);
        #1;
        check_pass_a("p1", '{3, 8, 13, 18}, 21, 1);

        // ---------------- pass 2: 3-cycle grad_valid stall on index 2 ----------------
        gtab = '{34'h1_3F00_0000, 34'h1_3E80_0000, 34'h1_BE80_0000, 34'h0_0000_0000};
        exp_dw = gtab;
        clear_a();
        start_pass_a();
        repeat (11) @(posedge clk);
        #1 gv_a = 1'b0;
        repeat (3) @(posedge clk);
        #1 gv_a = 1'b1;
        wait_done_a();
        chk("p2_stall_ready", stall_ready, 3);
        check_pass_a("p2", '{3, 8, 16, 21}, 24, 2);

        // ---------------- pass 3: gradient clamp ----------------
        gtab = '{34'h1_4040_0000, 34'h1_C040_0000, 34'h3_7FC0_0000, 34'h1_3F00_0000};
`ifdef GRAD_CLIP_EN
        exp_dw = '{34'h1_3F80_0000, 34'h1_BF80_0000, 34'h0_0000_0000, 34'h1_3F00_0000};
`else
        exp_dw = gtab;
`endif
        clear_a();
        start_pass_a();
        wait_done_a();
        check_pass_a("p3", '{3, 8, 13, 18}, 21, 3);

        // ---------------- pass 4: reset during WAIT_RES of index 1 ----------------
        gtab = '{34'h1_3E80_0000, 34'h1_3E80_0000, 34'h1_3E80_0000, 34'h1_3E80_0000};
        clear_a();
        start_pass_a();
        repeat (8) @(posedge clk);
        #1;
        chk("mid_en_before_rst", en_q.size(), 2);
        rst = 1'b1;
        #1;
        chk("mid_rst_ctl",   {busy_a, done_a, gr_a, en_a, we_a}, 0);
        chk("mid_rst_addr",  {rda_a, wa_a}, 0);
        chk("mid_rst_data",  {ow_a, dw_a}, 0);
        chk("mid_rst_wdata", wd_a, 0);
        chk("mid_rst_pc",    pc_a, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_writes", wa_q.size(), 1);
        exp_mem[0] = exp_mem[0] + gtab[0];

        // ---------------- pass 5: restart from index 0 ----------------
        exp_dw = gtab;
        clear_a();
        start_pass_a();
        wait_done_a();
        chk("p5_fetch_addr", fetch_addr, 0);
        check_pass_a("p5", '{3, 8, 13, 18}, 21, 1);

        // ---------------- instance B: N=1, L=0 ----------------
        gv_b = 1'b1;
        @(negedge clk) start_b = 1'b1;
        @(posedge clk);
        #1 s_b = cyc;
        start_b = 1'b0;
        for (int i = 0; i < 50 && done_cyc_b < 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("b_en_count", enb_q.size(), 1);
        chk("b_en_cyc",   enb_q[0], 3);
        chk("b_wa",       wab_q[0], 0);
        chk("b_wd",       wdb_q[0], ONE + 34'h1_3E80_0000);
        chk("b_done_cyc", done_cyc_b, 5);
        chk("b_pc",       pc_b, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/adam_update_sequencer.md
# adam_update_sequencer

Initiator for the Adam weight-update datapath. Walks a layer's weights in index order. For each weight it:
- reads the stored weight from the weight memory,
- accepts one back-propagated gradient over a valid/ready stream,
- issues exactly one single-cycle enable to the Adam update block,
- writes the updated weight back to memory.

Exactly NUMBER_WEIGHTS enables are issued per pass, so the Adam block's internal moment-index counter stays aligned with the weight index.

## Interface
- BIT_WIDTH, 32: IEEE-754 single field width.
- EXTRA_BIT, 2: exception-tag width prefixed to every value (00 zero, 01 normal, 10 inf, 11 NaN).
- NUMBER_WEIGHTS, 4: weights per pass, ≥1.
- UPDATE_LATENCY, 1: cycles from the enable cycle's end to updated weight valid, ≥0.
- Derived: W = BIT_WIDTH+EXTRA_BIT; AW = max(1, $clog2(NUMBER_WEIGHTS)).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a pass; sampled in IDLE only.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse at end of pass.
- pass_count  out  16  completed passes; wraps.
- grad_valid  in  1  gradient available.
- grad_data  in  W  gradient g(t) for current index.
- grad_ready  out  1  gradient accepted this cycle.
- rd_addr  out  AW  weight memory read address.
- rd_data  in  W  read data, valid one cycle after rd_addr.
- old_weight  out  W  to Adam OLD_WEIGHT.
- delta_weight  out  W  to Adam DELTA_WEIGHT.
- adam_enable  out  1  to Adam ADAM_ENABLE.
- updated_weight  in  W  from Adam UPDATED_WEIGHT.
- wr_en  out  1  weight memory write strobe.
- wr_addr  out  AW  write address.
- wr_data  out  W  write data.

## Operation
- FSM states: IDLE, FETCH, WAIT_GRAD, ISSUE, WAIT_RES, WRITE, DONE.
- IDLE: start=1 → FETCH, idx=0.
- FETCH: rd_addr=idx; → WAIT_GRAD.
- WAIT_GRAD: captures rd_data into the old-weight register on entry. grad_ready=1 while in this state. On grad_valid&grad_ready, captures grad_data (through the clip stage) into the delta register and → ISSUE.
- ISSUE: adam_enable=1 for exactly one cycle. → WAIT_RES if UPDATE_LATENCY>0, else → WRITE with updated_weight sampled at this edge.
- WAIT_RES: latency counter runs UPDATE_LATENCY cycles; updated_weight captured on the final edge; → WRITE.
- WRITE: wr_en=1, wr_addr=idx, wr_data=captured result. If idx==NUMBER_WEIGHTS-1 → DONE; else idx+1 → FETCH.
- DONE: done=1, pass_count+1 (mod 2^16); → IDLE.
- busy=1 in every state except IDLE.
- old_weight/delta_weight are driven from registers and held stable from ISSUE until the next capture.
- start outside IDLE: ignored.
- grad_valid outside WAIT_GRAD: ignored, not consumed.
- No gradient skipping: zero and tagged gradients still produce an enable, to keep index alignment.

## Timing
- Reset values: busy 0, done 0, grad_ready 0, adam_enable 0, wr_en 0, rd_addr 0, wr_addr 0, wr_data 0, old_weight 0, delta_weight 0, pass_count 0; state IDLE, idx 0.
- Per weight with gradient ready: 4+UPDATE_LATENCY cycles. Each grad_valid stall cycle adds 1.
- Pass: start edge at cycle 0. FETCH of weight 0 in cycle 1. done in cycle 1+NUMBER_WEIGHTS*(4+UPDATE_LATENCY). IDLE next cycle; a new start can be accepted in that cycle.
- Reset mid-pass: all outputs return to reset values immediately and no pending write completes. The Adam block shares rst, so moment state restarts consistently. The next pass starts at index 0.

## Configuration
- GRAD_CLIP_EN defined: captured gradients pass through a clamp.
  - Tag 01 with |value| > 1.0 (bits[30:0] > 0x3F800000), or tag 10: replaced by ±1.0 with the original sign, i.e. {01, s, 0x3F800000[30:0]}.
  - Tag 11 (NaN): replaced by {00, 32'h0}.
  - All other values pass unchanged.
- GRAD_CLIP_EN undefined: grad_data is captured unchanged; no clamp logic is present.

## Structure
- Shared package adam_pkg holds:
  - W and exception-tag constants;
  - the FSM state enum;
  - CLIP_MAG = {2'b01, 32'h3F800000};
  - Adam coefficients beta_1, beta_2, 1-beta_1, 1-beta_2, epsilon.
- One sub-module: grad_clip, combinational, W in/W out. It is instantiated only under GRAD_CLIP_EN.

## Test plan
- N=4, L=1, grad_valid held high, rd_data={01,0x3F800000}: adam_enable pulses 4 times, each 1 cycle wide, 5 cycles apart; wr_addr 0,1,2,3; done at cycle 21; pass_count=1.
- grad_valid low for 3 cycles during index 2: FSM holds in WAIT_GRAD with grad_ready=1 and no enable; done at cycle 24.
- start pulsed at cycle 5 of a pass: ignored. Second start after done: second pass runs; pass_count=2.
- GRAD_CLIP_EN, inputs {01,0x40400000}, {01,0xC0400000}, {11,0x7FC00000}, {01,0x3F000000} → delta_weight {01,0x3F800000}, {01,0xBF800000}, {00,0}, {01,0x3F000000}. Without the macro, all four pass unchanged.
- rst asserted during WAIT_RES of index 1: all outputs 0 immediately, no wr_en. The next start fetches rd_addr=0.
- N=1, L=0: single enable, wr_addr=0, done at cycle 5.
